// File: rtl/tohost_pkg.sv
// Shared definitions for the tohost/UART host-interface responder: register
// word selects, STATUS bit positions and the transmit FSM state type.
package tohost_pkg;

   // Register selects, compared against d_addr[3:2]
   localparam logic [1:0] TOHOST_OFS = 2'd0;
   localparam logic [1:0] TXDATA_OFS = 2'd1;
   localparam logic [1:0] STATUS_OFS = 2'd2;

   localparam int unsigned ST_FIFO_FULL  = 0;
   localparam int unsigned ST_FIFO_EMPTY = 1;
   localparam int unsigned ST_TX_BUSY    = 2;
   localparam int unsigned ST_OVERFLOW   = 3;
   localparam int unsigned ST_HALTED     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; pop data is the head entry.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;
   logic [CW-1:0]    count_d;

   // Fullness is judged on the registered count only
   assign do_push_c = push && !full;
   assign do_pop_c  = pop && !empty;
   assign head_c    = mem[rd_ptr];

   always_comb begin
      count_d = count;
      if (do_push_c && !do_pop_c) begin
         count_d = count + CW'(1);
      end else if (!do_push_c && do_pop_c) begin
         count_d = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_d;
         full  <= (count_d == CW'(DEPTH));
         empty <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/tohost_uart.sv
// Host-interface responder: TOHOST halt/pass latch, TXDATA FIFO and 8N1 transmitter.
// Define TOHOST_UART_SIM_EN to echo characters and report/finish on halt in simulation.
module tohost_uart
   import tohost_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h8000_1000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_we,
   input  logic        d_re,
   output logic [31:0] d_rdata,
   output logic        tx,
   output logic        halted,
   output logic        pass,
   output logic [30:0] exit_code
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

   logic              hit_c;
   logic [1:0]        sel_c;
   logic              wr_tohost_c;
   logic              wr_txdata_c;
   logic [31:0]       status_c;
   logic              overflow;

   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              pop_c;

   uart_state_t       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shreg_q, shreg_d;
   logic              tx_d;

   logic              unused_c;

   assign hit_c       = (d_addr[31:4] == BASE_ADDR[31:4]);
   assign sel_c       = d_addr[3:2];
   assign wr_tohost_c = d_we && hit_c && (sel_c == TOHOST_OFS);
   assign wr_txdata_c = d_we && hit_c && (sel_c == TXDATA_OFS);
   assign unused_c    = ^{d_addr[1:0], fifo_count};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (wr_txdata_c),
      .pop    (pop_c),
      .wdata  (d_wdata[7:0]),
      .head_c (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_comb begin
      status_c                = '0;
      status_c[ST_FIFO_FULL]  = fifo_full;
      status_c[ST_FIFO_EMPTY] = fifo_empty;
      status_c[ST_TX_BUSY]    = (state_q != IDLE);
      status_c[ST_OVERFLOW]   = overflow;
      status_c[ST_HALTED]     = halted;
   end

   // Halt latch, overflow flag and load data; loads see pre-store state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted    <= 1'b0;
         pass      <= 1'b0;
         exit_code <= '0;
         overflow  <= 1'b0;
         d_rdata   <= '0;
      end else begin
         if (wr_tohost_c && d_wdata[0] && !halted) begin
            halted    <= 1'b1;
            exit_code <= d_wdata[31:1];
            pass      <= (d_wdata[31:1] == 31'd0);
         end
         if (wr_txdata_c && fifo_full) overflow <= 1'b1;
         if (d_re) d_rdata <= (hit_c && (sel_c == STATUS_OFS)) ? status_c : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx      <= tx_d;
      end
   end

   // 8N1 transmitter; the shift register moves the next data bit into [0]
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx;
      pop_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               shreg_d = fifo_head;
               tx_d    = 1'b0;
               baud_d  = BAUD_MAX;
               state_d = START;
            end
         end
         START: begin
            if (baud_q == '0) begin
               tx_d    = shreg_q[0];
               baud_d  = BAUD_MAX;
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_q == '0) begin
               baud_d = BAUD_MAX;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_q == '0) begin
               state_d = IDLE;
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef TOHOST_UART_SIM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         if (wr_txdata_c && !fifo_full) $write("%c", d_wdata[7:0]);
         if (wr_tohost_c && d_wdata[0] && !halted) begin
            if (d_wdata[31:1] == 31'd0) $display("PASS");
            else                        $display("FAIL %0d", d_wdata[31:1]);
         end
         if (halted && fifo_empty && (state_q == IDLE)) $finish;
      end
   end
`else
`endif

endmodule

// File: tb/tb_tohost_uart.sv
// Directed bench for tohost_uart: register vectors from a table, then
// hand-written frame, overflow, halt and mid-frame reset sequences.
module tb_tohost_uart;

   localparam int unsigned HN = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_we = 1'b0;
   logic        d_re = 1'b0;
   logic [31:0] d_rdata;
   logic        tx;
   logic        halted;
   logic        pass;
   logic [30:0] exit_code;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic hist [HN];

   tohost_uart #(
      .BASE_ADDR    (32'h8000_1000),
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_we      (d_we),
      .d_re      (d_re),
      .d_rdata   (d_rdata),
      .tx        (tx),
      .halted    (halted),
      .pass      (pass),
      .exit_code (exit_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // tx history indexed by cycle number, sampled mid-cycle
   always @(negedge clk) hist[cyc % HN] <= tx;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_halted;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
      d_addr  = a;
      d_wdata = w;
      d_we    = 1'b1;
      @(negedge clk);
      d_we    = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
      d_addr = a;
      d_re   = 1'b1;
      @(negedge clk);
      d_re   = 1'b0;
      r      = d_rdata;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Compare 40 recorded samples starting at cycle index start with an 8N1 frame of b
   task automatic check_frame(input string name, input int start, input logic [7:0] b);
      logic [39:0] exp_bits;
      logic [39:0] got_bits;
      for (int i = 0; i < 40; i++) begin
         if (i < 4)       exp_bits[i] = 1'b0;
         else if (i < 36) exp_bits[i] = b[(i - 4) / 4];
         else             exp_bits[i] = 1'b1;
         got_bits[i] = hist[(start + i) % HN];
      end
      chk(name, 64'(got_bits), 64'(exp_bits));
   endtask

   initial begin
      logic [31:0] r;
      int base;
      int lows;

      vecs[0] = '{1'b0, 1'b1, 32'h8000_1008, 32'h0,  32'h2, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h8000_100C, 32'h0,  32'h0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h8000_1008, 32'h1F, 32'h0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h8000_1008, 32'h0,  32'h2, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h8000_1000, 32'h0,  32'h2, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 32'h9000_1008, 32'h0,  32'h0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 32'h8000_100A, 32'h0,  32'h2, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 32'h8000_100C, 32'h1,  32'h2, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 32'h9000_1000, 32'h1,  32'h2, 1'b0};
      vecs[9] = '{1'b0, 1'b1, 32'h8000_1008, 32'h0,  32'h2, 1'b0};

      @(negedge clk);
      do_reset();
      chk("reset_tx", 64'(tx), 64'd1);
      chk("reset_halted", 64'(halted), 64'd0);
      chk("reset_pass", 64'(pass), 64'd0);
      chk("reset_exit_code", 64'(exit_code), 64'd0);
      chk("reset_rdata", 64'(d_rdata), 64'd0);

      for (int i = 0; i < 10; i++) begin
         d_we    = vecs[i].we;
         d_re    = vecs[i].re;
         d_addr  = vecs[i].addr;
         d_wdata = vecs[i].wdata;
         @(negedge clk);
         d_we = 1'b0;
         d_re = 1'b0;
         chk($sformatf("vec%0d_rdata", i), 64'(d_rdata), 64'(vecs[i].exp_rdata));
         chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(vecs[i].exp_halted));
      end

      // Single byte: tx low from the cycle after the push edge
      bus_write(32'h8000_1004, 32'h41);
      base = cyc;
      chk("single_pre_start_tx", 64'(tx), 64'd1);
      wait_cyc(base + 40);
      bus_read(32'h8000_1008, r);
      chk("single_status_in_stop", 64'(r), 64'h6);
      bus_read(32'h8000_1008, r);
      chk("single_status_after", 64'(r), 64'h2);
      check_frame("single_frame", base + 1, 8'h41);
      chk("single_idle_after", 64'(hist[(base + 41) % HN]), 64'd1);

      // Overflow: one byte starts a frame, six more back-to-back fill and overflow
      bus_write(32'h8000_1004, 32'h30);
      base = cyc;
      for (int k = 1; k <= 6; k++) bus_write(32'h8000_1004, 32'h30 + k);
      wait_cyc(base + 41);
      // Sampled on the idle cycle between frames 0 and 1
      bus_read(32'h8000_1008, r);
      chk("ovf_status_full", 64'(r), 64'h9);
      wait_cyc(base + 230);
      for (int k = 0; k < 5; k++) begin
         check_frame($sformatf("ovf_frame%0d", k), base + 1 + 41 * k, 8'(8'h30 + k));
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_gap%0d", k), 64'(hist[(base + 41 + 41 * k) % HN]), 64'd1);
      end
      lows = 0;
      for (int i = base + 205; i < base + 226; i++) if (hist[i % HN] == 1'b0) lows++;
      chk("ovf_no_sixth_frame", 64'(lows), 64'd0);
      bus_read(32'h8000_1008, r);
      chk("ovf_status_drained", 64'(r), 64'hA);

      // Pass, then a later TOHOST write must not change the latch
      bus_write(32'h8000_1000, 32'h1);
      chk("pass_halted", 64'(halted), 64'd1);
      chk("pass_pass", 64'(pass), 64'd1);
      chk("pass_exit_code", 64'(exit_code), 64'd0);
      bus_write(32'h8000_1000, 32'h7);
      chk("pass_sticky_halted", 64'(halted), 64'd1);
      chk("pass_sticky_pass", 64'(pass), 64'd1);
      chk("pass_sticky_exit_code", 64'(exit_code), 64'd0);
      bus_read(32'h8000_1008, r);
      chk("pass_status", 64'(r), 64'h1A);

      // Fail path after reset
      @(negedge clk);
      do_reset();
      chk("fail_reset_rdata", 64'(d_rdata), 64'd0);
      chk("fail_reset_halted", 64'(halted), 64'd0);
      bus_write(32'h8000_1000, 32'h0);
      chk("fail_zero_write_halted", 64'(halted), 64'd0);
      bus_write(32'h8000_1000, 32'h7);
      chk("fail_halted", 64'(halted), 64'd1);
      chk("fail_pass", 64'(pass), 64'd0);
      chk("fail_exit_code", 64'(exit_code), 64'd3);

      // Pushes after halt still drain
      bus_write(32'h8000_1004, 32'h55);
      base = cyc;
      wait_cyc(base + 42);
      check_frame("post_halt_frame", base + 1, 8'h55);

      // Reset during data bit 3 of 0xA5 (bit value 0) with a second byte queued
      bus_write(32'h8000_1004, 32'hA5);
      base = cyc;
      bus_write(32'h8000_1004, 32'h5A);
      wait_cyc(base + 18);
      chk("midframe_bit3_low", 64'(tx), 64'd0);
      reset = 1'b0;
      #1;
      chk("midframe_tx_async_high", 64'(tx), 64'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      base = cyc;
      bus_read(32'h8000_1008, r);
      chk("midframe_status_empty", 64'(r), 64'h2);
      wait_cyc(base + 62);
      lows = 0;
      for (int i = base + 1; i < base + 61; i++) if (hist[i % HN] == 1'b0) lows++;
      chk("midframe_no_frames_after", 64'(lows), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
